seq_counter: RTL

//   Timing sequence counter feeding the T-signal decoder: produces the 3-bit

---
 rtl/seq_pkg.sv | 14 +
 rtl/seq_event_cnt.sv | 19 +
 rtl/seq_counter.sv | 100 ++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the T-step sequence counter.
package seq_pkg;

    localparam int unsigned T_CNT_W             = 3;
    localparam int unsigned MAX_T_DEFAULT       = 7;
    localparam int unsigned INSTR_CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } seq_state_e;

endpackage

// File: rtl/seq_event_cnt.sv
// Free-running event counter: counts enabled cycles, synchronous clear, wraps silently.
module seq_event_cnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/seq_counter.sv
// T-step sequence counter (T0..MAX_T) with clear, stall, halt/start, wrap and instruction count.
// Optional SEQ_STEP_EN adds a `step` input gating the increment/wrap path for single-step debug.
module seq_counter
    import seq_pkg::*;
#(
    parameter int unsigned CNT_W       = T_CNT_W,
    parameter int unsigned MAX_T       = MAX_T_DEFAULT,
    parameter int unsigned INSTR_CNT_W = INSTR_CNT_W_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   halt,
    input  logic                   clr,
    input  logic                   stall,
`ifdef SEQ_STEP_EN
    input  logic                   step,
`endif
    output logic [CNT_W-1:0]       tcounts,
    output logic                   running,
    output logic                   wrap,
    output logic [INSTR_CNT_W-1:0] instr_count
);

    seq_state_e       state;
    seq_state_e       state_n;
    logic [CNT_W-1:0] tcounts_n;
    logic             wrap_n;
    logic             instr_inc_c;
    logic             step_ok_c;

`ifdef SEQ_STEP_EN
    assign step_ok_c = step;
`else
    assign step_ok_c = 1'b1;
`endif

    // State and step registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            tcounts <= '0;
            running <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state   <= state_n;
            tcounts <= tcounts_n;
            running <= (state_n == ST_RUN);
            wrap    <= wrap_n;
        end
    end

    // Next-state logic; in RUN the priority is halt > clr > stall > increment
    always_comb begin
        state_n     = state;
        tcounts_n   = tcounts;
        wrap_n      = 1'b0;
        instr_inc_c = 1'b0;
        case (state)
            ST_RUN: begin
                if (halt) begin
                    state_n   = ST_HALTED;
                    tcounts_n = '0;
                end else if (clr) begin
                    tcounts_n   = '0;
                    instr_inc_c = 1'b1;
                end else if (stall) begin
                    tcounts_n = tcounts;
                end else if (step_ok_c) begin
                    if (tcounts == CNT_W'(MAX_T)) begin
                        tcounts_n   = '0;
                        wrap_n      = 1'b1;
                        instr_inc_c = 1'b1;
                    end else begin
                        tcounts_n = tcounts + CNT_W'(1);
                    end
                end
            end
            default: begin
                // IDLE/HALTED: T0 held; the first RUN cycle also sits at T0
                tcounts_n = '0;
                if (halt) begin
                    state_n = ST_HALTED;
                end else if (start) begin
                    state_n = ST_RUN;
                end
            end
        endcase
    end

    seq_event_cnt #(
        .W(INSTR_CNT_W)
    ) u_instr_cnt (
        .clk  (clk),
        .clr  (rst),
        .en   (instr_inc_c),
        .count(instr_count)
    );

endmodule
